// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving a comparator's B operand.
// Optional SAR_EARLY_EXIT_EN: an equal flag ends the search on that trial.
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIAL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] probe_q, probe_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] adj;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    idx_m1;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            probe_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        probe_d  = probe_q;
        result_d = result_q;
        idx_d    = idx_q;
        err_d    = err_q;
        idx_m1   = idx_q - IW'(1);
        // Trial decision: A below probe means the trial bit must be dropped
        adj      = probe_q;
        if (less) adj[idx_q] = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                probe_d = '0;
                if (start) begin
                    probe_d[WIDTH-1] = 1'b1;
                    idx_d            = IW'(WIDTH - 1);
                    err_d            = 1'b0;
                    state_d          = S_TRIAL;
                end
            end
            S_TRIAL: begin
                if (!$onehot({less, equal, greater})) err_d = 1'b1;
`ifdef SAR_EARLY_EXIT_EN
                if (equal) begin
                    result_d = probe_q;
                    state_d  = S_DONE;
                end else
`endif
                if (idx_q == '0) begin
                    probe_d  = adj;
                    result_d = adj;
                    state_d  = S_DONE;
                end else begin
                    probe_d         = adj;
                    probe_d[idx_m1] = 1'b1;
                    idx_d           = idx_m1;
                end
            end
            S_DONE: begin
                probe_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                probe_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign probe  = probe_q;
    assign result = result_q;
    assign err    = err_q;
    assign busy   = (state_q == S_TRIAL);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: table vectors, corner sequences,
// and random searches against a binary-search reference model.
module tb_sar_search_ctrl;

    localparam int W = 4;
`ifdef SAR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         less, equal, greater;
    logic [W-1:0] probe, result;
    logic         busy, done, err;

    logic [W-1:0] a_val;
    logic         force_bad;

    int checks   = 0;
    int failures = 0;

    int seq[W];
    int model_n;

    typedef struct {
        logic [W-1:0] a;
        int           bad_k;
        int           restart_k;
        int           exp_n;
        logic [W-1:0] exp_res;
        logic         exp_err;
    } vec_t;

    vec_t vecs[6];

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .less    (less),
        .equal   (equal),
        .greater (greater),
        .probe   (probe),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Comparator behaviour, with an optional illegal-flag override
    always_comb begin
        less    = (a_val < probe);
        equal   = (a_val == probe);
        greater = (a_val > probe);
        if (force_bad) begin
            less    = 1'b1;
            greater = 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Binary search: trial k keeps the top k bits of A and tries the next bit
    task automatic model(input int a);
        int p;
        model_n = 0;
        for (int k = 0; k < W; k++) begin
            p = ((a >> (W - k)) << (W - k)) | (1 << (W - 1 - k));
            seq[k] = p;
            model_n++;
            if (EARLY && p == a) break;
        end
    endtask

    // Entered and left at posedge+1 with the DUT idle
    task automatic run_search(input logic [W-1:0] a, input int bad_k,
                              input int restart_k, input int exp_n,
                              input logic [W-1:0] exp_res,
                              input logic exp_err);
        model(int'(a));
        a_val = a;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < exp_n; k++) begin
            force_bad = (k == bad_k);
            start     = (k == restart_k);
            @(negedge clk);
            chk("trial_busy", int'(busy), 1);
            chk("trial_done", int'(done), 0);
            chk("trial_probe", int'(probe), (k < W) ? seq[k] : -1);
            chk("trial_err", int'(err), int'(bad_k >= 0 && k > bad_k));
            @(posedge clk); #1;
            force_bad = 1'b0;
            start     = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", int'(done), 1);
        chk("done_busy", int'(busy), 0);
        chk("result", int'(result), int'(exp_res));
        chk("done_err", int'(err), int'(exp_err));
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("idle_probe", int'(probe), 0);
        chk("result_held", int'(result), int'(exp_res));
        @(posedge clk); #1;
    endtask

    initial begin
        int a, bad;

        vecs[0] = '{4'd10, -1, -1, EARLY ? 3 : 4, 4'd10, 1'b0};
        vecs[1] = '{4'd15, -1, -1, 4, 4'd15, 1'b0};
        vecs[2] = '{4'd0,  -1, -1, 4, 4'd0,  1'b0};
        vecs[3] = '{4'd8,  -1, -1, EARLY ? 1 : 4, 4'd8, 1'b0};
        vecs[4] = '{4'd11,  1, -1, 4, 4'd11, 1'b1};
        vecs[5] = '{4'd10, -1,  1, EARLY ? 3 : 4, 4'd10, 1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        force_bad = 1'b0;
        a_val     = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_probe", int'(probe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_search(vecs[i].a, vecs[i].bad_k, vecs[i].restart_k,
                       vecs[i].exp_n, vecs[i].exp_res, vecs[i].exp_err);

        // Reset in cycle 3 of a search aborts it
        a_val = 4'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("abort_c1_probe", int'(probe), 8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_probe", int'(probe), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_done", int'(done), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_no_done", int'(done), 0);
        chk("abort_idle_busy", int'(busy), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, (1 << W) - 1));
            model(a);
            bad = -1;
            if ($urandom_range(0, 2) == 0) begin
                bad = int'($urandom_range(0, model_n - 1));
                if (seq[bad] <= a) bad = -1;
            end
            run_search(W'(a), bad, -1, model_n, W'(a), bad >= 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller that sits on the input/output side of the `comparator` block.
- It drives the comparator's B operand (`probe`) while an unknown value is held on the comparator's A operand.
- It reads back less/equal/greater and recovers the unknown value, MSB-first, in WIDTH trial cycles.
- It is the active counterpart to the purely combinational comparator: it generates the operands and consumes the flags.

Parameters:
- WIDTH, 4, operand width in bits; must match the comparator's data width; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a search; sampled only in IDLE.
- less  input  1  comparator flag, A < B (unsigned), where B = probe.
- equal  input  1  comparator flag, A == B.
- greater  input  1  comparator flag, A > B.
- probe  output  WIDTH  trial value driven to the comparator's Data_in_B.
- busy  output  1  high while a search is in progress (TRIAL state).
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  recovered value of A; held until the next start.
- err  output  1  sticky flag: flags were not one-hot during a trial.

Behaviour:
- Reset: synchronous and active-high; sampled on the rising edge of clk. While rst=1, next edge sets:
  - state=IDLE;
  - probe, result = 0;
  - busy, done, err = 0;
  - bit index = 0.
- Reset mid-search aborts immediately. No done pulse is produced, and result is cleared.
- The comparator is combinational. Flags are valid in the same cycle as probe, and are sampled at the end of each TRIAL cycle.
- States: IDLE, TRIAL, DONE.
- IDLE:
  - busy=0; probe holds 0.
  - On start=1: probe <= 1<<(WIDTH-1), idx <= WIDTH-1, err <= 0, state <= TRIAL.
- TRIAL:
  - busy=1; one trial per cycle.
  - If less=1, clear probe[idx]; otherwise keep it.
  - If idx==0: result <= adjusted probe, state <= DONE.
  - Else: set probe[idx-1], idx <= idx-1.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - probe <= 0, state <= IDLE.
  - result stays stable until the next start accepts.
- Latency: start sampled at edge 0 means TRIAL occupies cycles 1..WIDTH, and done is high in cycle WIDTH+1. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy or in DONE is ignored; no queuing.
- Flag check: in TRIAL, if {less,equal,greater} is not one-hot, err <= 1.
  - err stays set until the next accepted start or reset.
  - The search still completes, treating less as the decision bit.
- Arithmetic: unsigned only. Bit-wise decisions never carry, so no overflow.
- Boundaries:
  - A=0 yields less on every trial → result 0.
  - A=2^WIDTH-1 never yields less → result all ones.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN.
- Defined: in TRIAL, equal=1 ends the search that cycle.
  - result <= current probe; state <= DONE regardless of idx.
  - done appears in cycle k+1, where k is the trial that hit equal.
- Undefined: equal does not affect control flow; every search takes exactly WIDTH trials.

Test Plan:
- WIDTH=4, A=10, pulse start → probe sequence 8,12,10,11 on cycles 1..4; done in cycle 5; result=10; err=0. With SAR_EARLY_EXIT_EN: probes 8,12,10; done in cycle 4; result=10.
- A=15 → probes 8,12,14,15; result=15. A=0 → probes 8,4,2,1; result=0; done in cycle 5 in both cases.
- A=8 with SAR_EARLY_EXIT_EN → single probe 8; done in cycle 2; result=8. Without the macro: probes 8,12,10,9; result=8; done in cycle 5.
- Force less=1 and greater=1 during trial 2 with A=11 → err=1 after that edge; search completes with done in cycle 5; err cleared by the next start.
- Assert start again in cycle 2 of a search → ignored; the probe sequence is unchanged. Assert rst in cycle 3 → next cycle probe=0, busy=0, result=0, no done pulse.
